sdr_channel_arbiter: RTL

SDR_CHANNEL_ARBITER -- requirements
Module: sdr_channel_arbiter

---
 rtl/board_pkg.sv | 39 +++
 rtl/sdr_arb_starve_ctr.sv | 31 +++
 rtl/sdr_channel_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared board-level SDRAM definitions: channel indices, bus widths and the arbiter state set.
// The REFRESH state exists only when SDR_ARB_REFRESH_EN is defined.
package board_pkg;

    localparam int SDR_ADDR_W = 25;
    localparam int SDR_DATA_W = 64;
    localparam int SDR_NUM_CH = 4;

    typedef enum logic [1:0] {
        SDR_CH_CPU    = 2'd0,
        SDR_CH_AUDIO  = 2'd1,
        SDR_CH_BG     = 2'd2,
        SDR_CH_SPRITE = 2'd3
    } sdr_ch_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESP    = 3'd3
`ifdef SDR_ARB_REFRESH_EN
        , ST_REFRESH = 3'd4
`endif
    } arb_state_e;

    // Starved requesters form the pool when any exist; lowest index in the pool wins.
    function automatic sdr_ch_e pick_channel(input logic [SDR_NUM_CH-1:0] req,
                                             input logic [SDR_NUM_CH-1:0] starved);
        logic [SDR_NUM_CH-1:0] pool;
        pick_channel = SDR_CH_CPU;
        pool = (|starved) ? starved : req;
        for (int i = SDR_NUM_CH - 1; i >= 0; i--) begin
            if (pool[i]) begin
                pick_channel = sdr_ch_e'(i[1:0]);
            end
        end
    endfunction

endpackage

// File: rtl/sdr_arb_starve_ctr.sv
// Per-channel starvation counter: counts IDLE arbitration losses while the channel requests,
// saturating at STARVE_LIMIT; clears on a win or whenever the request is low.
module sdr_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req,
    input  logic decide,
    input  logic won,
    output logic starved
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (!req || (decide && won)) begin
            count_reg <= '0;
        end else if (decide && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign starved = req && (count_reg == LIMIT);

endmodule

// File: rtl/sdr_channel_arbiter.sv
// Four-channel SDRAM read arbiter with starvation guard and single-transaction pipeline.
// Optional refresh path enabled by defining SDR_ARB_REFRESH_EN.
module sdr_channel_arbiter
    import board_pkg::*;
#(
    parameter int STARVE_LIMIT = 64
) (
    input  logic                                  clk_sys,
    input  logic                                  reset_n,
    input  logic [SDR_NUM_CH-1:0]                 ch_req,
    input  logic [SDR_NUM_CH-1:0][SDR_ADDR_W-1:0] ch_addr,
    output logic [SDR_NUM_CH-1:0]                 ch_rdy,
    output logic [SDR_DATA_W-1:0]                 ch_dout,
    output logic                                  mem_req,
    output logic [SDR_ADDR_W-1:0]                 mem_addr,
    input  logic                                  mem_ack,
    input  logic                                  mem_valid,
    input  logic [SDR_DATA_W-1:0]                 mem_data,
    input  logic                                  refresh_req,
    output logic                                  mem_refresh
);

    arb_state_e              state_reg;
    sdr_ch_e                 grant_reg;
    logic                    mem_req_reg;
    logic [SDR_ADDR_W-1:0]   mem_addr_reg;
    logic [SDR_NUM_CH-1:0]   ch_rdy_reg;
    logic [SDR_DATA_W-1:0]   ch_dout_reg;

    logic [SDR_NUM_CH-1:0]   eligible;
    logic [SDR_NUM_CH-1:0]   starved;
    logic [SDR_NUM_CH-1:0]   won_vec;
    sdr_ch_e                 grant_next;
    logic                    refresh_wins;
    logic                    decide;

    // A channel whose completion pulse is showing cannot be re-granted in that cycle.
    assign eligible   = ch_req & ~ch_rdy_reg;
    assign grant_next = pick_channel(eligible, starved & eligible);
    assign won_vec    = 4'b0001 << grant_next;

`ifdef SDR_ARB_REFRESH_EN
    logic mem_refresh_reg;
    assign refresh_wins = refresh_req;
    assign mem_refresh  = mem_refresh_reg;
`else
    logic unused_refresh;
    assign unused_refresh = refresh_req;
    assign refresh_wins   = 1'b0;
    assign mem_refresh    = 1'b0;
`endif

    // Only a real channel grant counts as an arbitration decision for the starve counters.
    assign decide = (state_reg == ST_IDLE) && (|eligible) && !refresh_wins;

    generate
        for (genvar gi = 0; gi < SDR_NUM_CH; gi++) begin : g_starve
            sdr_arb_starve_ctr #(
                .STARVE_LIMIT(STARVE_LIMIT)
            ) u_starve_ctr (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .req     (ch_req[gi]),
                .decide  (decide),
                .won     (won_vec[gi]),
                .starved (starved[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= SDR_CH_CPU;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            ch_rdy_reg   <= '0;
            ch_dout_reg  <= '0;
`ifdef SDR_ARB_REFRESH_EN
            mem_refresh_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
`ifdef SDR_ARB_REFRESH_EN
                    if (refresh_req) begin
                        mem_refresh_reg <= 1'b1;
                        state_reg       <= ST_REFRESH;
                    end else
`endif
                    if (|eligible) begin
                        grant_reg    <= grant_next;
                        mem_addr_reg <= ch_addr[grant_next];
                        mem_req_reg  <= 1'b1;
                        state_reg    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        ch_dout_reg <= mem_data;
                        ch_rdy_reg  <= 4'b0001 << grant_reg;
                        state_reg   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ch_rdy_reg <= '0;
                    state_reg  <= ST_IDLE;
                end
`ifdef SDR_ARB_REFRESH_EN
                ST_REFRESH: begin
                    if (mem_ack) begin
                        mem_refresh_reg <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign ch_rdy   = ch_rdy_reg;
    assign ch_dout  = ch_dout_reg;

endmodule
